bytewrite_sdp_wr_merge: RTL and testbench

//  Upstream write front-end for the byte-write simple-dual-port no-change RAM.

---
 rtl/bytewrite_pkg.sv | 20 ++
 rtl/bytewrite_idle_timer.sv | 28 ++
 rtl/bytewrite_sdp_wr_merge.sv | 176 +++++++++++++++++
 tb/tb_bytewrite_sdp_wr_merge.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bytewrite_pkg.sv
// Shared types for the byte-write SDP RAM write front-end: FSM state encoding,
// lane-index width and default geometry for the lane mask / RAM word types.
package bytewrite_pkg;

   localparam int NUM_COL_DEF        = 4;
   localparam int COL_WIDTH_DEF      = 8;
   localparam int ADDR_WIDTH_DEF     = 10;
   localparam int TIMEOUT_CYCLES_DEF = 16;
   localparam int LANE_W             = $clog2(NUM_COL_DEF);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef logic [NUM_COL_DEF-1:0]               lane_mask_t;
   typedef logic [NUM_COL_DEF*COL_WIDTH_DEF-1:0] word_t;

endpackage

// File: rtl/bytewrite_idle_timer.sv
// Idle counter for the write-merge buffer: counts enabled edges and pulses
// expire on the TIMEOUT_CYCLES-th one; any disabled edge restarts the count.
module bytewrite_idle_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic count_en,
   output logic expire
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt;

   assign expire = count_en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!count_en || expire) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/bytewrite_sdp_wr_merge.sv
// Byte-stream to masked-word write coalescer for the byte-write SDP RAM.
// Optional idle auto-flush is built when FLUSH_TIMEOUT_EN is defined.
module bytewrite_sdp_wr_merge
   import bytewrite_pkg::*;
#(
   parameter  int NUM_COL        = NUM_COL_DEF,
   parameter  int COL_WIDTH      = COL_WIDTH_DEF,
   parameter  int ADDR_WIDTH     = ADDR_WIDTH_DEF,
   parameter  int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int DATA_WIDTH     = NUM_COL * COL_WIDTH,
   localparam int LW             = $clog2(NUM_COL)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [ADDR_WIDTH+LW-1:0] s_addr,
   input  logic [COL_WIDTH-1:0]     s_data,
   input  logic                     s_last,
   input  logic                     flush,
   output logic                     ena,
   output logic [NUM_COL-1:0]       we,
   output logic [ADDR_WIDTH-1:0]    write_addr,
   output logic [DATA_WIDTH-1:0]    din,
   output logic                     busy
);

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH-1:0]   buf_addr, buf_addr_nxt;
   logic [NUM_COL-1:0]      buf_mask, buf_mask_nxt;
   logic [DATA_WIDTH-1:0]   buf_data, buf_data_nxt;

   logic                    emit;
   logic [ADDR_WIDTH-1:0]   emit_addr;
   logic [NUM_COL-1:0]      emit_mask;
   logic [DATA_WIDTH-1:0]   emit_data;
   logic                    expire;

   // Incoming byte placed in its lane of an otherwise zero word.
   logic                    accept, closing, same_word;
   logic [LW-1:0]           in_lane;
   logic [ADDR_WIDTH-1:0]   in_word;
   logic [NUM_COL-1:0]      in_mask, merged_mask;
   logic [DATA_WIDTH-1:0]   in_data, lane_field, merged_data;

   assign accept      = s_valid && s_ready;
   assign closing     = s_last || flush;
   assign in_lane     = s_addr[LW-1:0];
   assign in_word     = s_addr[LW +: ADDR_WIDTH];
   assign in_mask     = NUM_COL'(1) << in_lane;
   assign in_data     = DATA_WIDTH'(s_data) << (in_lane * COL_WIDTH);
   assign lane_field  = DATA_WIDTH'({COL_WIDTH{1'b1}}) << (in_lane * COL_WIDTH);
   assign same_word   = (in_word == buf_addr);
   assign merged_mask = buf_mask | in_mask;
   assign merged_data = (buf_data & ~lane_field) | in_data;
   assign busy        = (state != EMPTY);

`ifdef FLUSH_TIMEOUT_EN
   logic idle_en;

   assign idle_en = (state == HOLD) && !accept && !flush;

   bytewrite_idle_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_idle_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .count_en (idle_en),
      .expire   (expire)
   );
`else
   logic unused_timeout;

   assign expire         = 1'b0;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (accept && !closing) state_nxt = HOLD;
         HOLD: begin
            if (accept) begin
               if (same_word) state_nxt = (&merged_mask || closing) ? EMPTY : HOLD;
               else           state_nxt = closing ? DRAIN : HOLD;
            end else if (flush || expire) begin
               state_nxt = EMPTY;
            end
         end
         DRAIN:   state_nxt = EMPTY;
         default: state_nxt = EMPTY;
      endcase
   end

   // NOTE: every output of a combinational block gets a default first so no
   // path through the case statement can infer a latch.
   always_comb begin
      emit         = 1'b0;
      emit_addr    = buf_addr;
      emit_mask    = buf_mask;
      emit_data    = buf_data;
      buf_addr_nxt = buf_addr;
      buf_mask_nxt = buf_mask;
      buf_data_nxt = buf_data;
      case (state)
         EMPTY: begin
            if (accept && closing) begin
               emit      = 1'b1;
               emit_addr = in_word;
               emit_mask = in_mask;
               emit_data = in_data;
            end else if (accept) begin
               buf_addr_nxt = in_word;
               buf_mask_nxt = in_mask;
               buf_data_nxt = in_data;
            end
         end
         HOLD: begin
            if (accept && same_word) begin
               if (&merged_mask || closing) begin
                  emit      = 1'b1;
                  emit_mask = merged_mask;
                  emit_data = merged_data;
               end else begin
                  buf_mask_nxt = merged_mask;
                  buf_data_nxt = merged_data;
               end
            end else if (accept) begin
               // Old word goes out now; the new byte waits in the buffer.
               emit         = 1'b1;
               buf_addr_nxt = in_word;
               buf_mask_nxt = in_mask;
               buf_data_nxt = in_data;
            end else if (flush || expire) begin
               emit = 1'b1;
            end
         end
         DRAIN:   emit = 1'b1;
         default: emit = 1'b0;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values regardless of statement order.
   // NOTE: the buffer is reset as well; it is only a few flops and keeps a
   // discarded byte from ever reappearing after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_addr   <= '0;
         buf_mask   <= '0;
         buf_data   <= '0;
         s_ready    <= 1'b0;
         ena        <= 1'b0;
         we         <= '0;
         write_addr <= '0;
         din        <= '0;
      end else begin
         buf_addr <= buf_addr_nxt;
         buf_mask <= buf_mask_nxt;
         buf_data <= buf_data_nxt;
         s_ready  <= (state_nxt != DRAIN);
         ena      <= emit;
         we       <= emit ? emit_mask : '0;
         if (emit) begin
            write_addr <= emit_addr;
            din        <= emit_data;
         end
      end
   end

endmodule

// File: tb/tb_bytewrite_sdp_wr_merge.sv
// Self-checking bench for bytewrite_sdp_wr_merge: directed scenarios plus a
// randomized byte stream scored against a byte-buffer reference model.
module tb_bytewrite_sdp_wr_merge;

   localparam int NUM_COL    = 4;
   localparam int COL_WIDTH  = 8;
   localparam int ADDR_WIDTH = 10;
   localparam int TIMEOUT    = 16;
   localparam int LW         = 2;

   logic                      clk = 1'b0;
   logic                      rst_n = 1'b0;
   logic                      s_valid = 1'b0;
   logic                      s_ready;
   logic [ADDR_WIDTH+LW-1:0]  s_addr = '0;
   logic [COL_WIDTH-1:0]      s_data = '0;
   logic                      s_last = 1'b0;
   logic                      flush = 1'b0;
   logic                      ena;
   logic [NUM_COL-1:0]        we;
   logic [ADDR_WIDTH-1:0]     write_addr;
   logic [NUM_COL*COL_WIDTH-1:0] din;
   logic                      busy;

   bytewrite_sdp_wr_merge dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_addr     (s_addr),
      .s_data     (s_data),
      .s_last     (s_last),
      .flush      (flush),
      .ena        (ena),
      .we         (we),
      .write_addr (write_addr),
      .din        (din),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: a word address plus per-lane byte slots; each write is
   // queued as {addr, mask, data} in the order it must reach the RAM.
   int          m_addr;
   bit          m_has [NUM_COL];
   logic [7:0]  m_bytes [NUM_COL];
   bit          m_drain;
   int          m_idle;
   logic [45:0] exp_q[$];

   logic [45:0] last_wr;
   int          wr_count;
   logic        obs_ready;

   function automatic bit m_any();
      bit r = 0;
      for (int i = 0; i < NUM_COL; i++) r |= m_has[i];
      return r;
   endfunction

   function automatic bit m_full();
      bit r = 1;
      for (int i = 0; i < NUM_COL; i++) r &= m_has[i];
      return r;
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < NUM_COL; i++) begin
         m_has[i]   = 0;
         m_bytes[i] = '0;
      end
      m_idle = 0;
   endfunction

   function automatic void m_emit();
      logic [3:0]  mask = '0;
      logic [31:0] data = '0;
      for (int i = 0; i < NUM_COL; i++) begin
         if (m_has[i]) begin
            mask[i]          = 1'b1;
            data[i*8 +: 8]   = m_bytes[i];
         end
      end
      exp_q.push_back({10'(m_addr), mask, data});
      m_clear();
   endfunction

   function automatic void model_edge(bit acc, int baddr, logic [7:0] d, bit last, bit fl);
      int word = (baddr / NUM_COL) % (1 << ADDR_WIDTH);
      int lane = baddr % NUM_COL;
      m_drain = 0;
      if (acc) begin
         m_idle = 0;
         if (m_any() && word != m_addr) begin
            m_emit();
            m_addr = word;
            m_has[lane] = 1;
            m_bytes[lane] = d;
            if (last || fl) begin
               m_emit();
               m_drain = 1;
            end
         end else begin
            if (!m_any()) m_addr = word;
            m_has[lane]   = 1;
            m_bytes[lane] = d;
            if (m_full() || last || fl) m_emit();
         end
      end else if (m_any()) begin
         if (fl) m_emit();
`ifdef FLUSH_TIMEOUT_EN
         else begin
            m_idle++;
            if (m_idle == TIMEOUT) m_emit();
         end
`endif
      end
   endfunction

   task automatic sample();
      obs_ready = s_ready;
      check("ready", s_ready, !m_drain);
      check("busy", busy, m_any() || m_drain);
      check("ena_vs_we", ena, we != '0);
      if (ena) begin
         wr_count++;
         last_wr = {write_addr, we, din};
         check("write_expected", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) check("write", {write_addr, we, din}, exp_q.pop_front());
      end
   endtask

   task automatic step(input bit v, input int a, input logic [7:0] d, input bit l, input bit f);
      logic [ADDR_WIDTH+LW-1:0] av = (ADDR_WIDTH+LW)'(a);
      bit acc;
      s_valid = v;
      s_addr  = av;
      s_data  = d;
      s_last  = l;
      flush   = f;
      @(negedge clk);
      sample();
      acc = v && s_ready;
      @(posedge clk);
      model_edge(acc, a, d, l, f);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 0, 8'h00, 0, 0);
   endtask

   task automatic do_reset();
      s_valid = 0; s_last = 0; flush = 0; s_addr = '0; s_data = '0;
      rst_n = 1'b0;
      #2;
      check("reset_outputs", {ena, we, write_addr, din, busy, s_ready}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      exp_q.delete();
      m_clear();
      m_drain = 0;
   endtask

   int base;

   initial begin
      m_clear();
      m_drain  = 0;
      m_addr   = 0;
      wr_count = 0;
      last_wr  = '0;

      do_reset();

      // Full word merge
      base = wr_count;
      step(1, 'h10, 8'hAA, 0, 0);
      step(1, 'h11, 8'hBB, 0, 0);
      step(1, 'h12, 8'hCC, 0, 0);
      step(1, 'h13, 8'hDD, 0, 0);
      idle(1);
      check("full_count", wr_count - base, 1);
      check("full_write", last_wr, {10'd4, 4'b1111, 32'hDDCCBBAA});
      check("full_busy", busy, 0);

      // Word change emits the old word, new byte stays buffered
      step(1, 'h21, 8'h55, 0, 0);
      step(1, 'h40, 8'h66, 0, 0);
      idle(1);
      check("switch_write", last_wr, {10'd8, 4'b0010, 32'h00005500});
      check("switch_busy", busy, 1);
      step(0, 0, 8'h00, 0, 1);
      idle(1);
      check("switch_flush", last_wr, {10'd16, 4'b0001, 32'h00000066});

      // Word change with s_last: two writes, one back-pressure cycle
      step(1, 'h0C, 8'h11, 0, 0);
      step(1, 'h08, 8'h22, 1, 0);
      base = wr_count;
      idle(1);
      check("drain_w1", last_wr, {10'd3, 4'b0001, 32'h00000011});
      check("drain_ready", obs_ready, 0);
      idle(1);
      check("drain_w2", last_wr, {10'd2, 4'b0001, 32'h00000022});
      check("drain_count", wr_count - base, 2);

      // Same lane overwritten, then flush; flush in EMPTY does nothing
      step(1, 'h00, 8'h01, 0, 0);
      step(1, 'h00, 8'h02, 0, 0);
      base = wr_count;
      step(0, 0, 8'h00, 0, 1);
      idle(1);
      check("overwrite_count", wr_count - base, 1);
      check("overwrite_write", last_wr, {10'd0, 4'b0001, 32'h00000002});
      base = wr_count;
      step(0, 0, 8'h00, 0, 1);
      idle(2);
      check("flush_empty_count", wr_count - base, 0);

      // Idle buffer
      step(1, 'h05, 8'h77, 0, 0);
      base = wr_count;
`ifdef FLUSH_TIMEOUT_EN
      idle(TIMEOUT);
      check("timeout_early", wr_count - base, 0);
      idle(1);
      check("timeout_count", wr_count - base, 1);
      check("timeout_write", last_wr, {10'd1, 4'b0010, 32'h00007700});
`else
      idle(100);
      check("no_timeout_count", wr_count - base, 0);
      check("no_timeout_busy", busy, 1);
      step(0, 0, 8'h00, 0, 1);
      idle(1);
      check("no_timeout_flush", last_wr, {10'd1, 4'b0010, 32'h00007700});
`endif

      // Reset while in HOLD and while in DRAIN discards the buffer
      step(1, 'h30, 8'h99, 0, 0);
      do_reset();
      base = wr_count;
      idle(3);
      check("rst_hold_nowrite", wr_count - base, 0);
      step(1, 'h0C, 8'h11, 0, 0);
      step(1, 'h08, 8'h22, 1, 0);
      do_reset();
      base = wr_count;
      idle(3);
      check("rst_drain_nowrite", wr_count - base, 0);
      step(1, 'h3C, 8'h01, 0, 0);
      step(1, 'h3D, 8'h02, 0, 0);
      step(1, 'h3E, 8'h03, 0, 0);
      step(1, 'h3F, 8'h04, 0, 0);
      idle(1);
      check("resume_write", last_wr, {10'd15, 4'b1111, 32'h04030201});

      // Word-address wrap: top word then word 0
      step(1, 'hFFF, 8'hE1, 0, 0);
      step(1, 'h000, 8'hE2, 1, 0);
      idle(2);
      check("wrap_write", last_wr, {10'd0, 4'b0001, 32'h000000E2});

      // Randomized stream against the model
      for (int i = 0; i < 3000; i++) begin
         int a;
         bit v, l, f;
         if ($urandom_range(0, 9) < 8) a = $urandom_range(0, 23);
         else                          a = $urandom_range(4088, 4095);
         v = ($urandom_range(0, 9) < 7);
         l = ($urandom_range(0, 9) == 0);
         f = ($urandom_range(0, 99) < 8);
         step(v, a, 8'($urandom), l, f);
      end
      step(0, 0, 8'h00, 0, 1);
      idle(3);
      check("final_queue_empty", exp_q.size(), 0);
      check("final_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
